ro_scan_ctrl: RTL and testbench
===============================

// Module: ro_scan_ctrl
// PURPOSE
//  Readout scheduler for the ETROC1 4x4 pixel array. Sequences the readout mux (RO_SEL, DMRO_COL) and
//  the row output-enable OE_DMRO, waits a settle time after each selection, and captures the muxed
//  30-bit word. Each captured word goes to the DMRO serializer over a valid/ready handshake.
//  Pixel index idx = {col[1:0], row[1:0]}. Column c holds pixels 4c..4c+3, and row r is pixel 4c+r.
// PARAMETERS
//  SETTLE_CYC  2   cycles between a select change and the data capture; legal range 1..15
//  DW          30  width of the data word
// PORTS
//  CLK         in   1     system clock; every register uses the rising edge
//  RST         in   1     synchronous, active-high reset
//  SCAN_EN     in   1     level; 1 = run the scan, 0 = stop at the next word boundary
//  SRO_MODE    in   1     1 = SRO readout, 0 = DMRO pixel scan; sampled only on the IDLE exit
//  FIX_PIX     in   1     1 = read PIX_SEL repeatedly, 0 = auto-scan pixels 0..15
//  PIX_SEL     in   4     fixed pixel index, used when FIX_PIX=1
//  DataIn      in   DW    word from the readout mux output
//  DataReady   in   1     downstream accepts the word
//  RO_SEL      out  1     readout mux select; 1 = SRO
//  DMRO_COL    out  2     column select = idx[3:2]
//  OE_DMRO     out  4     one-hot row enable = 1<<idx[1:0]; 0 in IDLE and in SRO mode
//  DataOut     out  DW    captured word
//  DataValid   out  1     DataOut is valid
//  PixIdx      out  4     index of the word on DataOut
//  FrameDone   out  1     one-cycle pulse when the pixel-15 word transfers in auto-scan
// BEHAVIOUR
//  - Reset: state=IDLE. RO_SEL, DMRO_COL, OE_DMRO, DataOut, DataValid, PixIdx, FrameDone, idx and cnt are all 0.
//  - All outputs are registered.
//  - State IDLE, exit: on an edge where SCAN_EN=1, go to SETTLE and cnt<=0.
//    - Latch SRO_MODE into RO_SEL.
//    - idx <= FIX_PIX ? PIX_SEL : 0.
//    - Load DMRO_COL and OE_DMRO from idx. In SRO mode DMRO_COL=0 and OE_DMRO=0.
//  - State SETTLE:
//    - Each edge: cnt<=cnt+1.
//    - When cnt==SETTLE_CYC-1: DataOut<=DataIn, PixIdx<=idx, DataValid<=1, go to VALID.
//    - The first DataValid edge comes exactly SETTLE_CYC edges after the edge that loaded the selects.
//  - State VALID:
//    - DataOut and PixIdx are held stable while DataReady=0.
//    - A transfer happens on an edge with DataValid & DataReady. On that edge DataValid<=0.
//    - Next idx: FIX_PIX ? PIX_SEL : idx+1, which wraps from 15 to 0. SRO mode does not change idx.
//    - If SCAN_EN=1: load the new selects, cnt<=0, go to SETTLE.
//    - If SCAN_EN=0: go to IDLE and clear OE_DMRO.
//  - Throughput with DataReady held at 1: one word every SETTLE_CYC+1 cycles.
//  - FrameDone=1 for exactly the transfer edge of the pixel-15 word, only when SRO_MODE=0 and FIX_PIX=0.
//  - SCAN_EN falling:
//    - In SETTLE: abort and go to IDLE with no word produced. idx is kept, but the IDLE exit reloads it.
//    - In VALID: the pending word is not dropped. It completes its handshake, then the block goes to IDLE.
//  - SRO_MODE or FIX_PIX changing mid-scan: SRO_MODE takes effect only at the next IDLE exit.
//    FIX_PIX and PIX_SEL take effect at the next idx update.
//  - RST=1 in any state returns everything to reset values on that edge. A pending DataValid is dropped.
// TESTING
//  1. Reset, SETTLE_CYC=2, SCAN_EN=1, DataReady=1, FIX_PIX=0, DataIn=idx*3
//     -> 16 words, PixIdx 0..15, DataOut=PixIdx*3, one word per 3 cycles.
//     -> The DMRO_COL/OE_DMRO sequence is (0,0001),(0,0010)...(3,1000).
//     -> FrameDone pulses once, on the PixIdx=15 transfer, then the scan wraps to PixIdx=0.
//  2. Backpressure: hold DataReady=0 for 5 cycles while PixIdx=4
//     -> DataValid stays 1, DataOut and PixIdx stay stable, and idx does not advance.
//     -> After DataReady=1, the next word is PixIdx=5.
//  3. FIX_PIX=1, PIX_SEL=9 -> DMRO_COL=2, OE_DMRO=0010, and every word has PixIdx=9. FrameDone never pulses.
//  4. SRO_MODE=1 at the IDLE exit -> RO_SEL=1, OE_DMRO=0, DMRO_COL=0, and PixIdx stays 0.
//     -> Toggling SRO_MODE mid-scan has no effect until IDLE.
//  5. Drop SCAN_EN during SETTLE -> next edge goes to IDLE with OE_DMRO=0 and DataValid never asserts.
//     Drop SCAN_EN during VALID with DataReady=0 -> the word is held until the ready edge, then IDLE.
//  6. RST=1 during VALID with DataValid=1 -> on the next edge all outputs are 0 and the state is IDLE.

Source files
------------

// File: rtl/ro_scan_ctrl.sv
// ro_scan_ctrl: readout scheduler for the ETROC1 4x4 pixel array.
// Steps the readout mux (RO_SEL, DMRO_COL, OE_DMRO) across pixels. After each
// select change it waits a settle time, captures the muxed word, and hands the
// word to the DMRO serializer over a valid/ready handshake.
module ro_scan_ctrl #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned DW         = 30
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          SCAN_EN,
    input  logic          SRO_MODE,
    input  logic          FIX_PIX,
    input  logic [3:0]    PIX_SEL,
    input  logic [DW-1:0] DataIn,
    input  logic          DataReady,
    output logic          RO_SEL,
    output logic [1:0]    DMRO_COL,
    output logic [3:0]    OE_DMRO,
    output logic [DW-1:0] DataOut,
    output logic          DataValid,
    output logic [3:0]    PixIdx,
    output logic          FrameDone
);

    localparam int unsigned CW       = 4;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_VALID  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          ro_sel_d;
    logic [1:0]    col_d;
    logic [3:0]    oe_d;
    logic [DW-1:0] data_d;
    logic          valid_d;
    logic [3:0]    pix_d;
    logic          frame_d;

    logic          load_sel;
    logic [3:0]    load_idx;
    logic [3:0]    idx_nxt;

    // Next-state and next-output logic; every register holds unless a state acts on it.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        ro_sel_d = RO_SEL;
        col_d    = DMRO_COL;
        oe_d     = OE_DMRO;
        data_d   = DataOut;
        valid_d  = DataValid;
        pix_d    = PixIdx;
        frame_d  = 1'b0;
        load_sel = 1'b0;
        load_idx = idx_q;
        // SRO readout has no pixel to step through, so idx stays put there.
        idx_nxt  = RO_SEL ? idx_q : (FIX_PIX ? PIX_SEL : idx_q + 4'd1);

        case (state_q)
            ST_IDLE: begin
                if (SCAN_EN) begin
                    state_d  = ST_SETTLE;
                    cnt_d    = '0;
                    ro_sel_d = SRO_MODE;
                    idx_d    = FIX_PIX ? PIX_SEL : 4'd0;
                    load_sel = 1'b1;
                    load_idx = FIX_PIX ? PIX_SEL : 4'd0;
                end
            end
            ST_SETTLE: begin
                if (!SCAN_EN) begin
                    // Abort before capture: no word is produced for this selection.
                    state_d = ST_IDLE;
                    oe_d    = 4'd0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        data_d  = DataIn;
                        pix_d   = idx_q;
                        valid_d = 1'b1;
                        state_d = ST_VALID;
                    end
                end
            end
            ST_VALID: begin
                if (DataReady) begin
                    valid_d = 1'b0;
                    frame_d = !RO_SEL && !FIX_PIX && (idx_q == 4'd15);
                    idx_d   = idx_nxt;
                    if (SCAN_EN) begin
                        state_d  = ST_SETTLE;
                        cnt_d    = '0;
                        load_sel = 1'b1;
                        load_idx = idx_nxt;
                    end else begin
                        state_d = ST_IDLE;
                        oe_d    = 4'd0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Drive the mux selects for a newly chosen pixel; SRO mode parks the DMRO mux.
        if (load_sel) begin
            col_d = ro_sel_d ? 2'd0 : load_idx[3:2];
            oe_d  = ro_sel_d ? 4'd0 : (4'b0001 << load_idx[1:0]);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            idx_q     <= 4'd0;
            cnt_q     <= '0;
            RO_SEL    <= 1'b0;
            DMRO_COL  <= 2'd0;
            OE_DMRO   <= 4'd0;
            DataOut   <= '0;
            DataValid <= 1'b0;
            PixIdx    <= 4'd0;
            FrameDone <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            RO_SEL    <= ro_sel_d;
            DMRO_COL  <= col_d;
            OE_DMRO   <= oe_d;
            DataOut   <= data_d;
            DataValid <= valid_d;
            PixIdx    <= pix_d;
            FrameDone <= frame_d;
        end
    end

endmodule

// File: tb/tb_ro_scan_ctrl.sv
// tb_ro_scan_ctrl: directed scenarios plus a randomized phase, all checked
// against a transaction-level model of the scan schedule kept in the bench.
module tb_ro_scan_ctrl;

    localparam int unsigned SETTLE = 2;
    localparam int unsigned DW     = 30;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          SCAN_EN = 1'b0;
    logic          SRO_MODE = 1'b0;
    logic          FIX_PIX = 1'b0;
    logic [3:0]    PIX_SEL = 4'd0;
    logic [DW-1:0] DataIn;
    logic          DataReady = 1'b0;
    logic          RO_SEL;
    logic [1:0]    DMRO_COL;
    logic [3:0]    OE_DMRO;
    logic [DW-1:0] DataOut;
    logic          DataValid;
    logic [3:0]    PixIdx;
    logic          FrameDone;

    logic [21:0]   salt = 22'd0;

    int n_chk = 0;
    int n_bad = 0;

    ro_scan_ctrl #(.SETTLE_CYC(SETTLE), .DW(DW)) dut (
        .CLK(CLK), .RST(RST), .SCAN_EN(SCAN_EN), .SRO_MODE(SRO_MODE),
        .FIX_PIX(FIX_PIX), .PIX_SEL(PIX_SEL), .DataIn(DataIn),
        .DataReady(DataReady), .RO_SEL(RO_SEL), .DMRO_COL(DMRO_COL),
        .OE_DMRO(OE_DMRO), .DataOut(DataOut), .DataValid(DataValid),
        .PixIdx(PixIdx), .FrameDone(FrameDone)
    );

    always #5 CLK = ~CLK;

    // Word the pixel array / SRO path presents for a given selection.
    function automatic logic [DW-1:0] word_of(input logic sro, input logic [3:0] idx,
                                              input logic [21:0] s);
        logic [DW-1:0] w;
        if (sro) w = 30'h2A55A5A5;
        else     w = DW'(idx) * DW'(3);
        return w ^ {s, 8'h00};
    endfunction

    // Readout mux model: drives the word of whatever the DUT currently selects.
    always_comb begin
        DataIn = 30'h3FFFFFFF;
        if (RO_SEL) DataIn = word_of(1'b1, 4'd0, salt);
        else begin
            for (int r = 0; r < 4; r++)
                if (OE_DMRO == (4'b0001 << r)) DataIn = word_of(1'b0, {DMRO_COL, 2'(r)}, salt);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    // Inputs as seen by the DUT at each edge.
    int   cyc = 0;
    logic e_rst = 1'b1, e_scan = 1'b0, e_sro = 1'b0, e_fix = 1'b0, e_ready = 1'b0;
    logic [3:0] e_sel = 4'd0;
    always @(posedge CLK) begin
        cyc     <= cyc + 1;
        e_rst   <= RST;
        e_scan  <= SCAN_EN;
        e_sro   <= SRO_MODE;
        e_fix   <= FIX_PIX;
        e_ready <= DataReady;
        e_sel   <= PIX_SEL;
    end

    // Transaction model: whether a scan is live, which pixel it should be reading,
    // when that selection was made, and what was on the output before this edge.
    logic          m_busy = 1'b0, m_sro = 1'b0, m_fexp;
    logic [3:0]    m_idx = 4'd0, m_nxt;
    int            m_load = 0, m_age;
    logic          p_valid = 1'b0;
    logic [3:0]    p_pix = 4'd0;
    logic [DW-1:0] p_data = '0;
    int            n_frame = 0;
    int            xfer_pix[$];
    int            xfer_cyc[$];

    always @(negedge CLK) begin
        if (cyc > 0) begin
            m_fexp = 1'b0;
            if (e_rst) begin
                m_busy = 1'b0;
                chk("rst_valid", 32'(DataValid), 32'd0);
                chk("rst_rosel", 32'(RO_SEL), 32'd0);
                chk("rst_col",   32'(DMRO_COL), 32'd0);
                chk("rst_pix",   32'(PixIdx), 32'd0);
                chk("rst_data",  32'(DataOut), 32'd0);
            end else if (p_valid) begin
                if (e_ready) begin
                    chk("xfer_valid_drop", 32'(DataValid), 32'd0);
                    m_fexp = (m_idx == 4'd15) && !m_sro && !e_fix;
                    m_nxt  = m_sro ? m_idx : (e_fix ? e_sel : m_idx + 4'd1);
                    xfer_pix.push_back(int'(p_pix));
                    xfer_cyc.push_back(cyc);
                    m_idx = m_nxt;
                    if (e_scan) m_load = cyc;
                    else        m_busy = 1'b0;
                end else begin
                    chk("hold_valid", 32'(DataValid), 32'd1);
                    chk("hold_data",  32'(DataOut), 32'(p_data));
                    chk("hold_pix",   32'(PixIdx), 32'(p_pix));
                end
            end else if (m_busy) begin
                if (!e_scan) m_busy = 1'b0;
                else begin
                    m_age = cyc - m_load;
                    chk("capture_time", 32'(DataValid), 32'(m_age == int'(SETTLE)));
                    if (DataValid) begin
                        chk("capture_pix",  32'(PixIdx), 32'(m_idx));
                        chk("capture_data", 32'(DataOut), 32'(word_of(m_sro, m_idx, salt)));
                    end
                end
            end else if (e_scan) begin
                m_busy = 1'b1;
                m_sro  = e_sro;
                m_idx  = e_fix ? e_sel : 4'd0;
                m_load = cyc;
            end
            chk("frame_done", 32'(FrameDone), 32'(m_fexp));
            if (FrameDone) n_frame++;
            if (m_busy) begin
                chk("sel_rosel", 32'(RO_SEL), 32'(m_sro));
                chk("sel_col",   32'(DMRO_COL), m_sro ? 32'd0 : 32'(m_idx[3:2]));
                chk("sel_oe",    32'(OE_DMRO), m_sro ? 32'd0 : (32'd1 << m_idx[1:0]));
            end else begin
                chk("idle_oe",    32'(OE_DMRO), 32'd0);
                chk("idle_valid", 32'(DataValid), 32'd0);
            end
            p_valid = DataValid;
            p_pix   = PixIdx;
            p_data  = DataOut;
        end
    end

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!DataValid && n < 100) begin
            tick();
            n++;
        end
        if (!DataValid) chk(tag, 32'(DataValid), 32'd1);
    endtask

    task automatic go_idle();
        SCAN_EN   = 1'b0;
        DataReady = 1'b1;
        repeat (8) tick();
    endtask

    int f0;
    int n_wait;

    initial begin
        // Reset
        tick();
        tick();
        chk("reset_oe", 32'(OE_DMRO), 32'd0);
        chk("reset_valid", 32'(DataValid), 32'd0);
        RST = 1'b0;
        tick();

        // Full auto-scan frame with DataReady held high
        SCAN_EN = 1'b1; DataReady = 1'b1; FIX_PIX = 1'b0; SRO_MODE = 1'b0;
        tick();
        chk("t1_load_col", 32'(DMRO_COL), 32'd0);
        chk("t1_load_oe",  32'(OE_DMRO), 32'b0001);
        chk("t1_settle_valid", 32'(DataValid), 32'd0);
        tick();
        chk("t1_settle_valid2", 32'(DataValid), 32'd0);
        tick();
        chk("t1_first_valid", 32'(DataValid), 32'd1);
        chk("t1_first_pix",   32'(PixIdx), 32'd0);
        chk("t1_first_data",  32'(DataOut), 32'd0);
        n_wait = 0;
        while (xfer_pix.size() < 17 && n_wait < 200) begin
            tick();
            n_wait++;
        end
        chk("t1_word_count", 32'(xfer_pix.size() >= 17), 32'd1);
        for (int i = 0; i < 17 && i < xfer_pix.size(); i++)
            chk("t1_pix_seq", 32'(xfer_pix[i]), 32'(i % 16));
        for (int i = 1; i < 17 && i < xfer_cyc.size(); i++)
            chk("t1_word_gap", 32'(xfer_cyc[i] - xfer_cyc[i-1]), 32'(SETTLE + 1));
        chk("t1_frame_count", 32'(n_frame), 32'd1);

        // Backpressure while pixel 4 is on the output
        n_wait = 0;
        while (!(DataValid && PixIdx == 4'd4) && n_wait < 200) begin
            tick();
            n_wait++;
        end
        chk("t2_reach_pix4", 32'(PixIdx), 32'd4);
        DataReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_valid", 32'(DataValid), 32'd1);
            chk("t2_hold_pix",   32'(PixIdx), 32'd4);
            chk("t2_hold_data",  32'(DataOut), 32'd12);
            chk("t2_hold_col",   32'(DMRO_COL), 32'd1);
            chk("t2_hold_oe",    32'(OE_DMRO), 32'b0001);
        end
        DataReady = 1'b1;
        tick();
        wait_valid("t2_next_timeout");
        chk("t2_next_pix", 32'(PixIdx), 32'd5);

        // Fixed pixel 9
        go_idle();
        f0 = n_frame;
        FIX_PIX = 1'b1; PIX_SEL = 4'd9; SCAN_EN = 1'b1;
        tick();
        chk("t3_col", 32'(DMRO_COL), 32'd2);
        chk("t3_oe",  32'(OE_DMRO), 32'b0010);
        for (int i = 0; i < 4; i++) begin
            wait_valid("t3_timeout");
            chk("t3_pix", 32'(PixIdx), 32'd9);
            tick();
        end
        chk("t3_no_frame", 32'(n_frame), 32'(f0));

        // SRO readout, SRO_MODE toggled mid-scan
        go_idle();
        FIX_PIX = 1'b0; SRO_MODE = 1'b1; SCAN_EN = 1'b1;
        tick();
        chk("t4_rosel", 32'(RO_SEL), 32'd1);
        chk("t4_oe",    32'(OE_DMRO), 32'd0);
        chk("t4_col",   32'(DMRO_COL), 32'd0);
        wait_valid("t4_timeout");
        SRO_MODE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            wait_valid("t4_timeout2");
            chk("t4_pix",   32'(PixIdx), 32'd0);
            chk("t4_rosel_kept", 32'(RO_SEL), 32'd1);
        end

        // Abort in SETTLE
        go_idle();
        SCAN_EN = 1'b1;
        tick();
        chk("t5_loaded_oe", 32'(OE_DMRO), 32'b0001);
        SCAN_EN = 1'b0;
        tick();
        chk("t5_abort_oe", 32'(OE_DMRO), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_abort_novalid", 32'(DataValid), 32'd0);
        end
        // Stop during VALID under backpressure
        SCAN_EN = 1'b1; DataReady = 1'b0;
        wait_valid("t5_timeout");
        SCAN_EN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_pending_held", 32'(DataValid), 32'd1);
        end
        DataReady = 1'b1;
        tick();
        chk("t5_done_valid", 32'(DataValid), 32'd0);
        chk("t5_done_oe",    32'(OE_DMRO), 32'd0);
        repeat (3) tick();
        chk("t5_stay_idle", 32'(DataValid), 32'd0);

        // Reset while a word is pending
        SCAN_EN = 1'b1; DataReady = 1'b0;
        wait_valid("t6_timeout");
        RST = 1'b1;
        tick();
        chk("t6_valid", 32'(DataValid), 32'd0);
        chk("t6_data",  32'(DataOut), 32'd0);
        chk("t6_oe",    32'(OE_DMRO), 32'd0);
        chk("t6_col",   32'(DMRO_COL), 32'd0);
        chk("t6_pix",   32'(PixIdx), 32'd0);
        chk("t6_rosel", 32'(RO_SEL), 32'd0);
        RST = 1'b0; SCAN_EN = 1'b0; DataReady = 1'b1;
        tick();

        // Randomized traffic, checked cycle by cycle by the model above
        for (int i = 0; i < 3000; i++) begin
            RST = ($urandom_range(0, 199) == 0);
            if (RST) salt = 22'($urandom);
            SCAN_EN   = ($urandom_range(0, 9) != 0);
            DataReady = ($urandom_range(0, 9) < 7);
            SRO_MODE  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 49) == 0) FIX_PIX = ~FIX_PIX;
            PIX_SEL   = 4'($urandom);
            tick();
        end
        RST = 1'b0; SCAN_EN = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
